// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised integer register file with a per-register busy scoreboard.
//   Decode reads operands and reserves destinations; writeback writes data
//   and releases the reservation. After reset a sequential sweep clears the
//   storage one entry per cycle, so the array needs no reset of its own and
//   can map onto block RAM.
//
// Ports
//   clk              clock
//   reset_trigger    synchronous active-high reset; restarts the clear sweep
//   rs_addr          packed read addresses, port p = [p*AW +: AW]
//   rs_value         packed registered read data, port p = [p*XLEN +: XLEN]
//   rs_busy          registered busy bit of each addressed register
//   write_trigger    writeback strobe
//   rd / write_value writeback address and data
//   reserve_trigger  reserve strobe (a write to reserve_rd is now in flight)
//   reserve_rd       register to reserve
//   reserve_conflict combinational: reserving a register that stays busy
//   busy_count       registered number of busy registers
//   init_done        high once the clear sweep has completed
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN       = 32,
    parameter int REG_COUNT  = 32,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    localparam int AW        = $clog2(REG_COUNT),
    localparam int CW        = $clog2(REG_COUNT + 1)
) (
    input  logic                       clk,
    input  logic                       reset_trigger,
    input  logic [READ_PORTS*AW-1:0]   rs_addr,
    output logic [READ_PORTS*XLEN-1:0] rs_value,
    output logic [READ_PORTS-1:0]      rs_busy,
    input  logic                       write_trigger,
    input  logic [AW-1:0]              rd,
    input  logic [XLEN-1:0]            write_value,
    input  logic                       reserve_trigger,
    input  logic [AW-1:0]              reserve_rd,
    output logic                       reserve_conflict,
    output logic [CW-1:0]              busy_count,
    output logic                       init_done
);

    // The busy vector spans the full address space so that any address can
    // index it; entries at or above REG_COUNT are never set and stay zero.
    localparam int              SPAN        = 1 << AW;
    localparam logic [AW:0]     REG_COUNT_W = (AW + 1)'(REG_COUNT);
    localparam logic [AW-1:0]   LAST_PTR    = AW'(REG_COUNT - 1);
    localparam logic [SPAN-1:0] ONE_HOT0    = {{(SPAN - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Address is backed by a real register: in range and not the hardwired zero.
    function automatic logic addr_legal(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < REG_COUNT_W);
        is_zero  = (ZERO_REG != 32'sd0) && (a == {AW{1'b0}});
        return in_range && !is_zero;
    endfunction

    state_t                     state_r;
    state_t                     state_next_s;
    logic [AW-1:0]              ptr_r;
    logic [AW-1:0]              ptr_next_s;
    logic                       run_s;
    logic                       wr_ok_s;
    logic                       res_ok_s;
    logic [SPAN-1:0]            wr_mask_s;
    logic [SPAN-1:0]            res_mask_s;
    logic [SPAN-1:0]            busy_r;
    logic [SPAN-1:0]            busy_next_s;
    logic                       busy_inc_s;
    logic                       busy_dec_s;
    logic [CW-1:0]              busy_count_r;
    logic [READ_PORTS*XLEN-1:0] rs_value_r;
    logic [READ_PORTS*XLEN-1:0] rs_value_next_s;
    logic [READ_PORTS-1:0]      rs_busy_r;
    logic [READ_PORTS-1:0]      rs_busy_next_s;
    logic                       init_done_r;
    logic [XLEN-1:0]            mem_r [REG_COUNT];

    // FSM state and sweep pointer register.
    always_ff @(posedge clk) begin
        if (reset_trigger) begin
            state_r <= ST_INIT;
            ptr_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // FSM next state: sweep every entry once, then stay in RUN until reset.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            ST_INIT: begin
                if (ptr_r == LAST_PTR) begin
                    state_next_s = ST_RUN;
                    ptr_next_s   = {AW{1'b0}};
                end else begin
                    state_next_s = ST_INIT;
                    ptr_next_s   = ptr_r + {{(AW - 1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
                ptr_next_s   = {AW{1'b0}};
            end
            default: begin
                state_next_s = ST_INIT;
                ptr_next_s   = {AW{1'b0}};
            end
        endcase
    end

    assign run_s    = (state_r == ST_RUN);
    assign wr_ok_s  = run_s && write_trigger && addr_legal(rd);
    assign res_ok_s = run_s && reserve_trigger && addr_legal(reserve_rd);

    // Busy update: the write clears first, then a reservation sets, so a
    // same-cycle reserve of the written register leaves it busy.
    always_comb begin
        wr_mask_s   = wr_ok_s  ? (ONE_HOT0 << rd)         : {SPAN{1'b0}};
        res_mask_s  = res_ok_s ? (ONE_HOT0 << reserve_rd) : {SPAN{1'b0}};
        busy_next_s = (busy_r & ~wr_mask_s) | res_mask_s;
        // Only real 0->1 / 1->0 transitions move the counter; a register that
        // is released and re-reserved in one cycle produces neither.
        busy_inc_s  = res_ok_s && busy_next_s[reserve_rd] && !busy_r[reserve_rd];
        busy_dec_s  = wr_ok_s && busy_r[rd] && !busy_next_s[rd];
    end

    // The new reservation fails only if the old one survives this cycle.
    assign reserve_conflict = res_ok_s && busy_r[reserve_rd] &&
                              !(wr_ok_s && (rd == reserve_rd));

    // Per-port read mux: illegal addresses and INIT read as zero.
    always_comb begin
        rs_value_next_s = {(READ_PORTS * XLEN){1'b0}};
        rs_busy_next_s  = {READ_PORTS{1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            if (run_s && addr_legal(rs_addr[p*AW +: AW])) begin
                if ((BYPASS != 32'sd0) && wr_ok_s && (rd == rs_addr[p*AW +: AW])) begin
                    rs_value_next_s[p*XLEN +: XLEN] = write_value;
                end else begin
                    rs_value_next_s[p*XLEN +: XLEN] = mem_r[rs_addr[p*AW +: AW]];
                end
                rs_busy_next_s[p] = busy_next_s[rs_addr[p*AW +: AW]];
            end else begin
                rs_value_next_s[p*XLEN +: XLEN] = {XLEN{1'b0}};
                rs_busy_next_s[p]               = 1'b0;
            end
        end
    end

    // Storage: sweep clears during INIT, writeback writes during RUN.
    always_ff @(posedge clk) begin
        if (!reset_trigger) begin
            if (state_r == ST_INIT) begin
                mem_r[ptr_r] <= {XLEN{1'b0}};
            end else if (wr_ok_s) begin
                mem_r[rd] <= write_value;
            end
        end
    end

    // Scoreboard, counter and registered read outputs.
    always_ff @(posedge clk) begin
        if (reset_trigger) begin
            busy_r       <= {SPAN{1'b0}};
            busy_count_r <= {CW{1'b0}};
            rs_value_r   <= {(READ_PORTS * XLEN){1'b0}};
            rs_busy_r    <= {READ_PORTS{1'b0}};
            init_done_r  <= 1'b0;
        end else begin
            busy_r       <= busy_next_s;
            busy_count_r <= busy_count_r + {{(CW - 1){1'b0}}, busy_inc_s}
                                         - {{(CW - 1){1'b0}}, busy_dec_s};
            rs_value_r   <= rs_value_next_s;
            rs_busy_r    <= rs_busy_next_s;
            // Rises one cycle after the FSM enters RUN.
            init_done_r  <= run_s;
        end
    end

    assign rs_value   = rs_value_r;
    assign rs_busy    = rs_busy_r;
    assign busy_count = busy_count_r;
    assign init_done  = init_done_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a 32-entry bypassing instance
// checked against a table and an array-based reference model, plus a
// 24-entry non-bypassing single-port instance for the boundary cases.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset_trigger;
    logic [9:0]  rs_addr;
    logic [63:0] rs_value;
    logic [1:0]  rs_busy;
    logic        write_trigger;
    logic [4:0]  rd;
    logic [31:0] write_value;
    logic        reserve_trigger;
    logic [4:0]  reserve_rd;
    logic        reserve_conflict;
    logic [5:0]  busy_count;
    logic        init_done;

    logic [4:0]  rs_addr2;
    logic [31:0] rs_value2;
    logic [0:0]  rs_busy2;
    logic        reserve_conflict2;
    logic [4:0]  busy_count2;
    logic        init_done2;

    assign rs_addr2 = rs_addr[4:0];

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(32), .REG_COUNT(32), .READ_PORTS(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset_trigger(reset_trigger), .rs_addr(rs_addr), .rs_value(rs_value),
        .rs_busy(rs_busy), .write_trigger(write_trigger), .rd(rd), .write_value(write_value),
        .reserve_trigger(reserve_trigger), .reserve_rd(reserve_rd),
        .reserve_conflict(reserve_conflict), .busy_count(busy_count), .init_done(init_done)
    );

    regfile_scoreboard #(.XLEN(32), .REG_COUNT(24), .READ_PORTS(1), .BYPASS(0), .ZERO_REG(1)) dut2 (
        .clk(clk), .reset_trigger(reset_trigger), .rs_addr(rs_addr2), .rs_value(rs_value2),
        .rs_busy(rs_busy2), .write_trigger(write_trigger), .rd(rd), .write_value(write_value),
        .reserve_trigger(reserve_trigger), .reserve_rd(reserve_rd),
        .reserve_conflict(reserve_conflict2), .busy_count(busy_count2), .init_done(init_done2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model of the 32-entry instance: plain arrays.
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    bit          use_model;
    logic        seen_conf;

    function automatic bit m_legal(input logic [4:0] a);
        return a != 5'd0;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic wr, input logic [4:0] r, input logic [31:0] v,
                         input logic res, input logic [4:0] rr,
                         input logic [4:0] a0, input logic [4:0] a1);
        write_trigger   = wr;
        rd              = r;
        write_value     = v;
        reserve_trigger = res;
        reserve_rd      = rr;
        rs_addr         = {a1, a0};
    endtask

    // One RUN cycle: predict from the model, check conflict mid-cycle and
    // registered outputs just after the edge.
    task automatic step();
        bit          conf_e;
        int          cnt;
        logic [4:0]  a;
        logic [31:0] ev [2];
        bit          eb [2];
        conf_e = reserve_trigger && m_legal(reserve_rd) && m_busy[reserve_rd] &&
                 !(write_trigger && m_legal(rd) && rd == reserve_rd);
        if (write_trigger && m_legal(rd)) begin
            m_val[rd]  = write_value;
            m_busy[rd] = 1'b0;
        end
        if (reserve_trigger && m_legal(reserve_rd)) m_busy[reserve_rd] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            a     = (p == 0) ? rs_addr[4:0] : rs_addr[9:5];
            ev[p] = m_legal(a) ? m_val[a] : 32'd0;
            eb[p] = m_legal(a) ? m_busy[a] : 1'b0;
        end
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
        @(negedge clk);
        seen_conf = reserve_conflict;
        if (use_model) chk("model_conflict", {63'd0, reserve_conflict}, {63'd0, conf_e});
        @(posedge clk);
        #1;
        if (use_model) begin
            chk("model_value0", {32'd0, rs_value[31:0]}, {32'd0, ev[0]});
            chk("model_value1", {32'd0, rs_value[63:32]}, {32'd0, ev[1]});
            chk("model_busy", {62'd0, rs_busy}, {62'd0, eb[1], eb[0]});
            chk("model_count", {58'd0, busy_count}, 64'(cnt));
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset_trigger = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_value", rs_value, 64'd0);
        chk("reset_busy", {62'd0, rs_busy}, 64'd0);
        chk("reset_count", {58'd0, busy_count}, 64'd0);
        chk("reset_init_done", {63'd0, init_done}, 64'd0);
        reset_trigger = 1'b0;
        m_clear();
    endtask

    // Count cycles to init_done on both instances; optionally try a write mid-sweep.
    task automatic wait_init(input bit try_write);
        int n1;
        int n2;
        n1 = 0;
        n2 = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (init_done && n1 == 0) n1 = i;
            if (init_done2 && n2 == 0) n2 = i;
            if (try_write && i == 20) drive(1'b1, 5'd2, 32'h5A5A_5A5A, 1'b1, 5'd2, 5'd2, 5'd2);
            if (try_write && i == 21) begin
                chk("init_read_zero", rs_value, 64'd0);
                chk("init_busy_zero", {62'd0, rs_busy}, 64'd0);
                drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
            end
            if (n1 != 0 && n2 != 0) break;
        end
        chk("init_latency_32", 64'(n1), 64'd33);
        chk("init_latency_24", 64'(n2), 64'd25);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wv;
        logic        res;
        logic [4:0]  rr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] ev0;
        logic [31:0] ev1;
        logic        eb0;
        logic        eb1;
        logic        econf;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[2]  = '{1'b1, 5'd5, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd5, 5'd5, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 6'd1};
        vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 6'd1};
        vt[5]  = '{1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd1};
        vt[7]  = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 1'b1, 1'b1, 1'b0, 6'd1};
        vt[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd2};
        vt[9]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 5'd3, 5'd4, 32'h33, 32'h0, 1'b0, 1'b1, 1'b0, 6'd2};
        vt[10] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd2};
        vt[11] = '{1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h44, 1'b0, 1'b0, 1'b0, 6'd1};
        vt[12] = '{1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 5'd9, 5'd3, 32'h90, 32'h33, 1'b0, 1'b0, 1'b0, 6'd0};

        use_model = 1'b0;
        m_clear();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset_trigger = 1'b1;

        // Sweep latency, reads during INIT, writes during INIT dropped.
        do_reset();
        wait_init(1'b1);
        use_model = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd2);
        step();
        chk("init_write_lost", {32'd0, rs_value[31:0]}, 64'd0);

        // Reset in the middle of the sweep restarts it.
        drive(1'b1, 5'd20, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd0);
        step();
        chk("reg20_written", {32'd0, rs_value[31:0]}, 64'hDEAD_BEEF);
        do_reset();
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        do_reset();
        wait_init(1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd20);
        step();
        chk("reg20_cleared", rs_value, 64'd0);

        // Directed table.
        use_model = 1'b0;
        for (int k = 0; k < 13; k++) begin
            drive(vt[k].wr, vt[k].rd, vt[k].wv, vt[k].res, vt[k].rr, vt[k].a0, vt[k].a1);
            step();
            chk($sformatf("vec%0d_conflict", k), {63'd0, seen_conf}, {63'd0, vt[k].econf});
            chk($sformatf("vec%0d_value", k), rs_value, {vt[k].ev1, vt[k].ev0});
            chk($sformatf("vec%0d_busy", k), {62'd0, rs_busy}, {62'd0, vt[k].eb1, vt[k].eb0});
            chk($sformatf("vec%0d_count", k), {58'd0, busy_count}, {58'd0, vt[k].ecnt});
        end

        // Randomised traffic against the model.
        use_model = 1'b1;
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (k % 7 == 0) rs_addr[9:5] = rd;
            if (k % 11 == 0) reserve_rd = rd;
            step();
        end

        // Boundary cases on the 24-entry, non-bypassing instance.
        do_reset();
        wait_init(1'b0);
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 5'd5, 5'd5);
        step();
        drive(1'b1, 5'd5, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd5, 5'd5);
        step();
        chk("nobypass_old_value", {32'd0, rs_value2}, 64'h1234_5678);
        chk("bypass_new_value", {32'd0, rs_value[31:0]}, 64'hCAFE_F00D);
        drive(1'b1, 5'd30, 32'h0000_1234, 1'b1, 5'd30, 5'd30, 5'd30);
        step();
        chk("addr30_read_same", {32'd0, rs_value2}, 64'd0);
        chk("addr30_busy", {63'd0, rs_busy2}, 64'd0);
        chk("addr30_count", {59'd0, busy_count2}, 64'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 5'd30, 5'd30);
        #1;
        chk("addr30_no_conflict", {63'd0, reserve_conflict2}, 64'd0);
        step();
        chk("addr30_read_later", {32'd0, rs_value2}, 64'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 5'd23, 5'd23);
        step();
        chk("reg23_busy", {63'd0, rs_busy2}, 64'd1);
        chk("reg23_count", {59'd0, busy_count2}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
